// File: rtl/ahb_sram_tester.sv
// AHB-Lite master that writes a seeded pattern to an SRAM region, reads it back
// back-to-back and reports error count, first failing address and pass/fail.
module ahb_sram_tester #(
  parameter int unsigned   AW     = 16,
  parameter int unsigned   NWORDS = 16,
  parameter logic [AW-1:0] BASE   = '0,
  parameter logic [31:0]   SEED   = 32'hA5C3_5A3C
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          start,
  input  logic          HREADY,
  input  logic          HRESP,
  input  logic [31:0]   HRDATA,
  output logic [1:0]    HTRANS,
  output logic [AW-1:0] HADDR,
  output logic          HWRITE,
  output logic [2:0]    HSIZE,
  output logic [31:0]   HWDATA,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [7:0]    err_cnt,
  output logic [AW-1:0] fail_addr
);

  localparam int unsigned   IW        = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(NWORDS - 1);
  localparam logic [1:0]    TR_IDLE   = 2'b00;
  localparam logic [1:0]    TR_NONSEQ = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_LAST, S_DONE} state_t;

  state_t        r_state,     w_state;
  logic [IW-1:0] r_idx,       w_idx;
  logic [1:0]    r_htrans,    w_htrans;
  logic [AW-1:0] r_haddr,     w_haddr;
  logic          r_hwrite,    w_hwrite;
  logic [31:0]   r_hwdata,    w_hwdata;
  logic          r_busy,      w_busy;
  logic          r_done,      w_done;
  logic          r_pass,      w_pass;
  logic [7:0]    r_err_cnt,   w_err_cnt;
  logic [AW-1:0] r_fail_addr, w_fail_addr;
  // Outstanding data phase: direction, address and expected read data
  logic          r_dp_wr,     w_dp_wr;
  logic          r_dp_rd,     w_dp_rd;
  logic [AW-1:0] r_dp_addr,   w_dp_addr;
  logic [31:0]   r_dp_exp,    w_dp_exp;
  logic          w_err;
  logic          w_last;

  function automatic logic [31:0] pat(input logic [IW-1:0] idx);
    logic [15:0] v;
    v = 16'(idx);
    return SEED ^ {~v, v};
  endfunction

  assign w_last = (r_idx == LAST_IDX);

  always_comb begin
    w_state     = r_state;
    w_idx       = r_idx;
    w_htrans    = r_htrans;
    w_haddr     = r_haddr;
    w_hwrite    = r_hwrite;
    w_hwdata    = r_hwdata;
    w_busy      = r_busy;
    w_done      = 1'b0;
    w_pass      = r_pass;
    w_err_cnt   = r_err_cnt;
    w_fail_addr = r_fail_addr;
    w_dp_wr     = r_dp_wr;
    w_dp_rd     = r_dp_rd;
    w_dp_addr   = r_dp_addr;
    w_dp_exp    = r_dp_exp;
    w_err       = 1'b0;

    // Data phase completes on HREADY; check it before a new one is loaded
    if (HREADY) begin
      if (r_dp_wr && HRESP) w_err = 1'b1;
      if (r_dp_rd && (HRESP || (HRDATA != r_dp_exp))) w_err = 1'b1;
      w_dp_wr = 1'b0;
      w_dp_rd = 1'b0;
    end
    if (w_err) begin
      if (r_err_cnt != 8'hFF) w_err_cnt = r_err_cnt + 8'd1;
      if (r_err_cnt == 8'd0)  w_fail_addr = r_dp_addr;
    end

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state     = S_WR;
          w_idx       = '0;
          w_htrans    = TR_NONSEQ;
          w_haddr     = BASE;
          w_hwrite    = 1'b1;
          w_busy      = 1'b1;
          w_pass      = 1'b0;
          w_err_cnt   = 8'd0;
          w_fail_addr = '0;
        end
      end
      S_WR: begin
        if (HREADY) begin
          w_hwdata  = pat(r_idx);
          w_dp_wr   = 1'b1;
          w_dp_addr = r_haddr;
          if (w_last) begin
            w_state  = S_RD;
            w_idx    = '0;
            w_haddr  = BASE;
            w_hwrite = 1'b0;
          end else begin
            w_idx   = r_idx + IW'(1);
            w_haddr = r_haddr + AW'(4);
          end
        end
      end
      S_RD: begin
        if (HREADY) begin
          w_dp_rd   = 1'b1;
          w_dp_addr = r_haddr;
          w_dp_exp  = pat(r_idx);
          if (w_last) begin
            w_state  = S_LAST;
            w_idx    = '0;
            w_htrans = TR_IDLE;
          end else begin
            w_idx   = r_idx + IW'(1);
            w_haddr = r_haddr + AW'(4);
          end
        end
      end
      S_LAST: begin
        if (HREADY) begin
          w_state = S_DONE;
          w_done  = 1'b1;
          w_busy  = 1'b0;
          w_pass  = (w_err_cnt == 8'd0);
        end
      end
      S_DONE: begin
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_htrans    <= TR_IDLE;
      r_haddr     <= '0;
      r_hwrite    <= 1'b0;
      r_hwdata    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_cnt   <= '0;
      r_fail_addr <= '0;
      r_dp_wr     <= 1'b0;
      r_dp_rd     <= 1'b0;
      r_dp_addr   <= '0;
      r_dp_exp    <= '0;
    end else begin
      r_state     <= w_state;
      r_idx       <= w_idx;
      r_htrans    <= w_htrans;
      r_haddr     <= w_haddr;
      r_hwrite    <= w_hwrite;
      r_hwdata    <= w_hwdata;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_pass      <= w_pass;
      r_err_cnt   <= w_err_cnt;
      r_fail_addr <= w_fail_addr;
      r_dp_wr     <= w_dp_wr;
      r_dp_rd     <= w_dp_rd;
      r_dp_addr   <= w_dp_addr;
      r_dp_exp    <= w_dp_exp;
    end
  end

  assign HTRANS    = r_htrans;
  assign HADDR     = r_haddr;
  assign HWRITE    = r_hwrite;
  assign HSIZE     = 3'b010;
  assign HWDATA    = r_hwdata;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_cnt   = r_err_cnt;
  assign fail_addr = r_fail_addr;

endmodule

// File: tb/tb_ahb_sram_tester.sv
// Bench for ahb_sram_tester: behavioural SRAM slave with stall/error injection,
// run results predicted from a high-level model and checked by a done-triggered monitor.
module tb_ahb_sram_tester;

  localparam int unsigned AW   = 16;
  localparam int          N    = 4;
  localparam logic [31:0] SEED = 32'hA5C3_5A3C;

  logic          HCLK, HRESETn, start, HREADY, HRESP;
  logic [31:0]   HRDATA;
  logic [1:0]    HTRANS;
  logic [AW-1:0] HADDR;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic [31:0]   HWDATA;
  logic          busy, done, pass;
  logic [7:0]    err_cnt;
  logic [AW-1:0] fail_addr;

  ahb_sram_tester #(.AW(AW), .NWORDS(N), .BASE(16'h0000), .SEED(SEED)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .HREADY(HREADY), .HRESP(HRESP),
    .HRDATA(HRDATA), .HTRANS(HTRANS), .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HWDATA(HWDATA), .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .fail_addr(fail_addr)
  );

  typedef struct {
    int            start_cyc;
    int            lat;
    logic [7:0]    ec;
    logic          ps;
    logic [AW-1:0] fa;
  } exp_t;

  typedef struct {
    logic [AW-1:0] a;
    logic          w;
  } acc_t;

  exp_t  exp_q[$];
  acc_t  acc_q[$];
  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;

  // Run configuration: per-cycle HREADY and fault injection (-1 = none)
  bit    cfg_hr [64];
  int    cfg_corrupt, cfg_rresp, cfg_wresp, cfg_restart, cfg_rst;
  bit    cfg_dir_stall;

  // Slave state
  logic [31:0]   mem [N];
  bit            dp_v, dp_wr;
  logic [AW-1:0] dp_addr;
  bit            p_hr, p_rst;
  logic [50:0]   p_bus;

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;

  function automatic logic [31:0] ref_pat(input int i);
    logic [15:0] v;
    v = i[15:0];
    return SEED ^ {~v, v};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic cfg_clean();
    for (int c = 0; c < 64; c++) cfg_hr[c] = 1'b1;
    cfg_corrupt = -1; cfg_rresp = -1; cfg_wresp = -1;
    cfg_restart = -1; cfg_rst = -1; cfg_dir_stall = 1'b0;
  endtask

  // One cycle of the SRAM slave, called just after a falling edge
  task automatic slave_cycle(input int c);
    int idx;
    bit hr;
    hr = (c >= 0 && c < 64) ? cfg_hr[c] : 1'b1;
    HREADY = hr;
    HRESP  = 1'b0;
    HRDATA = 32'h0;
    idx = int'(dp_addr >> 2) % N;
    if (dp_v && !dp_wr) begin
      HRDATA = mem[idx];
      if (idx == cfg_corrupt) HRDATA = HRDATA ^ 32'h1;
      if (hr && idx == cfg_rresp) HRESP = 1'b1;
    end else if (dp_v && dp_wr && hr && idx == cfg_wresp) begin
      HRESP = 1'b1;
    end
    if (hr) begin
      if (dp_v && dp_wr) begin
        chk("wdata", 64'(HWDATA), 64'(ref_pat(idx)));
        mem[idx] = HWDATA;
      end
      dp_v    = (HTRANS == 2'b10);
      dp_wr   = HWRITE;
      dp_addr = HADDR;
      if (dp_v) acc_q.push_back('{a: HADDR, w: HWRITE});
    end
    p_hr  = hr;
    p_rst = !HRESETn;
    p_bus = {HTRANS, HADDR, HWRITE, HWDATA};
  endtask

  task automatic do_run(input bit is_rst_run);
    exp_t          e;
    int            need, pos, len, nerr, i;
    bit            wr, bad_acc;
    logic [AW-1:0] first;
    for (int k = 0; k < N; k++) mem[k] = $urandom;
    cfg_hr[0] = 1'b1;
    // Run needs 2N address phases plus the final data phase, each one ready cycle
    need = 2 * N + 1;
    pos  = 0;
    for (int c = 1; c < 64; c++) begin
      if (need > 0 && cfg_hr[c]) begin
        need--;
        pos = c;
      end
    end
    e.lat = pos + 1;
    nerr  = 0;
    first = '0;
    for (int k = 0; k < 2 * N; k++) begin
      i  = k % N;
      wr = (k < N);
      bad_acc = wr ? (i == cfg_wresp) : (i == cfg_corrupt || i == cfg_rresp);
      if (bad_acc) begin
        if (nerr == 0) first = AW'(4 * i);
        nerr++;
      end
    end
    e.ec = 8'((nerr > 255) ? 255 : nerr);
    e.ps = (nerr == 0);
    e.fa = first;

    @(negedge HCLK);
    acc_q.delete();
    dp_v  = 1'b0;
    start = 1'b1;
    e.start_cyc = cyc;
    if (!is_rst_run) exp_q.push_back(e);
    slave_cycle(0);
    len = is_rst_run ? 20 : e.lat + 3;
    for (int c = 1; c <= len; c++) begin
      @(negedge HCLK);
      start   = (c == cfg_restart);
      HRESETn = (c == cfg_rst) ? 1'b0 : 1'b1;
      if (c == cfg_rst + 1) begin
        dp_v = 1'b0;
        chk("rst_mid_run", 64'({HTRANS, busy, err_cnt, HADDR, HWRITE, done}), 64'(0));
      end
      if (!p_hr && !p_rst)
        chk("stall_hold", 64'({HTRANS, HADDR, HWRITE, HWDATA}), 64'(p_bus));
      if (cfg_dir_stall && c >= 2 && c <= 4)
        chk("stall_values", 64'({HTRANS, HADDR, HWRITE, HWDATA}),
            64'({2'b10, 16'h0004, 1'b1, ref_pat(0)}));
      slave_cycle(c);
    end
    start = 1'b0;
    if (!is_rst_run) begin
      chk("pass_held", 64'(pass), 64'(e.ps));
      chk("err_cnt_held", 64'(err_cnt), 64'(e.ec));
    end else begin
      chk("pass_after_rst", 64'(pass), 64'(0));
    end
  endtask

  // Monitor: every done pulse is matched against the oldest predicted run
  initial begin : monitor
    exp_t e;
    bit   ok;
    forever begin
      @(negedge HCLK);
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL done_unexpected: got done=1 at cycle %0d want no done", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("latency", 64'(cyc - e.start_cyc), 64'(e.lat));
          chk("err_cnt", 64'(err_cnt), 64'(e.ec));
          chk("pass", 64'(pass), 64'(e.ps));
          chk("fail_addr", 64'(fail_addr), 64'(e.fa));
          chk("busy_at_done", 64'(busy), 64'(0));
          ok = (acc_q.size() == 2 * N);
          for (int k = 0; k < 2 * N; k++) begin
            if (ok && (acc_q[k].a != AW'(4 * (k % N)) || acc_q[k].w != (k < N))) ok = 1'b0;
          end
          chk("access_seq", 64'(ok), 64'(1));
        end
      end
    end
  end

  initial begin : stim
    HRESETn = 1'b0;
    start   = 1'b0;
    HREADY  = 1'b1;
    HRESP   = 1'b0;
    HRDATA  = 32'h0;
    dp_v    = 1'b0;
    dp_wr   = 1'b0;
    dp_addr = '0;
    p_hr    = 1'b1;
    p_rst   = 1'b1;
    p_bus   = '0;
    cfg_clean();
    repeat (3) @(negedge HCLK);
    chk("reset_bus", 64'({HTRANS, HADDR, HWRITE, HSIZE, HWDATA}), 64'({2'b00, 16'h0, 1'b0, 3'b010, 32'h0}));
    chk("reset_status", 64'({busy, done, pass, err_cnt, fail_addr}), 64'(0));
    HRESETn = 1'b1;
    @(negedge HCLK);

    cfg_clean(); do_run(1'b0);
    cfg_clean(); cfg_hr[2] = 1'b0; cfg_hr[3] = 1'b0; cfg_hr[4] = 1'b0;
    cfg_dir_stall = 1'b1; do_run(1'b0);
    cfg_clean(); cfg_corrupt = 2; do_run(1'b0);
    cfg_clean(); cfg_rresp = 1; do_run(1'b0);
    cfg_clean(); cfg_wresp = 3; do_run(1'b0);
    cfg_clean(); cfg_rst = 6; do_run(1'b1);
    cfg_clean(); do_run(1'b0);
    cfg_clean(); cfg_restart = 3; do_run(1'b0);

    for (int r = 0; r < 10; r++) begin
      cfg_clean();
      for (int c = 1; c < 64; c++) cfg_hr[c] = ($urandom_range(3) != 0);
      cfg_corrupt = ($urandom_range(2) == 0) ? int'($urandom_range(N - 1)) : -1;
      cfg_rresp   = ($urandom_range(3) == 0) ? int'($urandom_range(N - 1)) : -1;
      cfg_wresp   = ($urandom_range(3) == 0) ? int'($urandom_range(N - 1)) : -1;
      cfg_restart = ($urandom_range(3) == 0) ? int'($urandom_range(8, 1)) : -1;
      do_run(1'b0);
    end

    repeat (5) @(negedge HCLK);
    chk("pending_done", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
